// File: rtl/clock_pkg.sv
// Shared definitions for the clock-setting path: field indices, calendar
// limits, the set-sequencer state encoding, button event codes and the
// calendar helpers also used by current_time.
package clock_pkg;

   // Field selector values, in the order the right button walks them
   localparam logic [2:0] FLD_HOUR   = 3'd0;
   localparam logic [2:0] FLD_MINUTE = 3'd1;
   localparam logic [2:0] FLD_SECOND = 3'd2;
   localparam logic [2:0] FLD_YEAR   = 3'd3;
   localparam logic [2:0] FLD_MONTH  = 3'd4;
   localparam logic [2:0] FLD_DAY    = 3'd5;
   localparam logic [2:0] FLD_LAST   = FLD_DAY;

   // Calendar limits (the year range is a parameter of the sequencer)
   localparam int HOUR_MAX   = 23;
   localparam int MINUTE_MAX = 59;
   localparam int SECOND_MAX = 59;
   localparam int MONTH_MIN  = 1;
   localparam int MONTH_MAX  = 12;
   localparam int DAY_MIN    = 1;

   // Set-sequencer states
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EDIT   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   // One button event per cycle, already priority-resolved
   typedef enum logic [2:0] {
      EV_NONE,
      EV_MIDDLE,
      EV_RIGHT,
      EV_LEFT,
      EV_UP,
      EV_DOWN
   } btn_ev_e;

   // Days in a month; every year%4==0 is a leap year inside the settable range
   function automatic logic [4:0] days_in_month(input logic [15:0] year,
                                                input logic [5:0]  month);
      logic [4:0] dim;
      case (month)
         6'd4, 6'd6, 6'd9, 6'd11: dim = 5'd30;
         6'd2:                    dim = ((year % 16'd4) == 16'd0) ? 5'd29 : 5'd28;
         default:                 dim = 5'd31;
      endcase
      return dim;
   endfunction

   // One step up or down inside [lo, hi], wrapping at both ends
   function automatic logic [15:0] wrap_step(input logic [15:0] value,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi,
                                             input logic        inc);
      logic [15:0] res;
      if (inc) res = (value >= hi) ? lo : value + 16'd1;
      else     res = (value <= lo) ? hi : value - 16'd1;
      return res;
   endfunction

   // Saturate a value into [lo, hi]
   function automatic logic [15:0] clamp(input logic [15:0] value,
                                         input logic [15:0] lo,
                                         input logic [15:0] hi);
      logic [15:0] res;
      if (value < lo)      res = lo;
      else if (value > hi) res = hi;
      else                 res = value;
      return res;
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Rising-edge detector for the five set buttons with a fixed priority
// encoder, so the sequencer sees at most one event per cycle.
module btn_edge
   import clock_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    up,
   input  logic    down,
   input  logic    left,
   input  logic    right,
   input  logic    middle,
   output btn_ev_e ev
);

   logic [4:0] btn_d;
   logic [4:0] btn_q;
   logic [4:0] rise;

   // Current button levels packed as {middle, right, left, up, down}
   always_comb begin
      btn_d = {middle, right, left, up, down};
      rise  = btn_d & ~btn_q;
   end

   // Previous-value registers; a held button only rises once
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      if (rst) btn_q <= '0;
      else     btn_q <= btn_d;
   end

   // Priority: middle > right > left > up > down
   always_comb begin
      if (rise[4])      ev = EV_MIDDLE;
      else if (rise[3]) ev = EV_RIGHT;
      else if (rise[2]) ev = EV_LEFT;
      else if (rise[1]) ev = EV_UP;
      else if (rise[0]) ev = EV_DOWN;
      else              ev = EV_NONE;
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock-set sequencer: edits a shadow copy of the time/date from the
// buttons and hands it to current_time with a one-cycle load strobe.
module time_set_ctrl
   import clock_pkg::*;
#(
   parameter int YEAR_MIN  = 2000,
   parameter int YEAR_MAX  = 2099,
   parameter int TIMEOUT_S = 30,
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        sec_tick,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic        middle,
   input  logic [15:0] cur_year,
   input  logic [5:0]  cur_month,
   input  logic [10:0] cur_day,
   input  logic [10:0] cur_hour,
   input  logic [10:0] cur_minute,
   input  logic [10:0] cur_second,
   output logic [15:0] set_year,
   output logic [5:0]  set_month,
   output logic [10:0] set_day,
   output logic [10:0] set_hour,
   output logic [10:0] set_minute,
   output logic [10:0] set_second,
   output logic        load,
   output logic        editing,
   output logic [2:0]  field,
   output logic        blink
);

   localparam logic [15:0] YR_LO = 16'(YEAR_MIN);
   localparam logic [15:0] YR_HI = 16'(YEAR_MAX);
   // Timeout counter holds 0..TIMEOUT_S-1; the tick that would reach TIMEOUT_S exits
   localparam int TW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S);
   localparam int BW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_S - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   btn_ev_e       ev;
   logic          step_up;

   logic [1:0]    state_d,     state_q;
   logic [2:0]    field_d,     field_q;
   logic [15:0]   year_d,      year_q;
   logic [5:0]    month_d,     month_q;
   logic [10:0]   day_d,       day_q;
   logic [10:0]   hour_d,      hour_q;
   logic [10:0]   minute_d,    minute_q;
   logic [10:0]   second_d,    second_q;
   logic [TW-1:0] tmo_d,       tmo_q;
   logic [BW-1:0] blink_cnt_d, blink_cnt_q;
   logic          blink_d,     blink_q;
   logic          load_d,      load_q;

   btn_edge u_btn_edge (
      .clk    (clk),
      .rst    (rst),
      .up     (up),
      .down   (down),
      .left   (left),
      .right  (right),
      .middle (middle),
      .ev     (ev)
   );

   // Sequencer: capture on entry, field edits, timeout and commit
   always_comb begin
      // NOTE: every target gets a default first so no path infers a latch.
      state_d  = state_q;
      field_d  = field_q;
      year_d   = year_q;
      month_d  = month_q;
      day_d    = day_q;
      hour_d   = hour_q;
      minute_d = minute_q;
      second_d = second_q;
      tmo_d    = tmo_q;
      load_d   = 1'b0;
      step_up  = (ev == EV_UP);

      case (state_q)
         ST_IDLE: begin
            if (en && (ev == EV_MIDDLE)) begin
               // Live values may be out of range; saturate them on the way in
               year_d   = clamp(cur_year, YR_LO, YR_HI);
               month_d  = 6'(clamp({10'd0, cur_month}, 16'(MONTH_MIN), 16'(MONTH_MAX)));
               day_d    = 11'(clamp({5'd0, cur_day}, 16'(DAY_MIN),
                                    {11'd0, days_in_month(year_d, month_d)}));
               hour_d   = 11'(clamp({5'd0, cur_hour},   16'd0, 16'(HOUR_MAX)));
               minute_d = 11'(clamp({5'd0, cur_minute}, 16'd0, 16'(MINUTE_MAX)));
               second_d = 11'(clamp({5'd0, cur_second}, 16'd0, 16'(SECOND_MAX)));
               field_d  = FLD_HOUR;
               tmo_d    = '0;
               state_d  = ST_EDIT;
            end
         end

         ST_EDIT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (ev != EV_NONE) begin
               // Any accepted event restarts the inactivity window, even on a tick
               tmo_d = '0;
               case (ev)
                  EV_MIDDLE: state_d = ST_COMMIT;
                  EV_RIGHT:  field_d = (field_q == FLD_LAST) ? FLD_HOUR : field_q + 3'd1;
                  EV_LEFT:   field_d = (field_q == FLD_HOUR) ? FLD_LAST : field_q - 3'd1;
                  EV_UP, EV_DOWN: begin
                     case (field_q)
                        FLD_HOUR:   hour_d   = 11'(wrap_step({5'd0, hour_q}, 16'd0,
                                                             16'(HOUR_MAX), step_up));
                        FLD_MINUTE: minute_d = 11'(wrap_step({5'd0, minute_q}, 16'd0,
                                                             16'(MINUTE_MAX), step_up));
                        FLD_SECOND: second_d = 11'(wrap_step({5'd0, second_q}, 16'd0,
                                                             16'(SECOND_MAX), step_up));
                        FLD_YEAR: begin
                           year_d = wrap_step(year_q, YR_LO, YR_HI, step_up);
                           day_d  = 11'(clamp({5'd0, day_q}, 16'(DAY_MIN),
                                              {11'd0, days_in_month(year_d, month_q)}));
                        end
                        FLD_MONTH: begin
                           month_d = 6'(wrap_step({10'd0, month_q}, 16'(MONTH_MIN),
                                                  16'(MONTH_MAX), step_up));
                           day_d   = 11'(clamp({5'd0, day_q}, 16'(DAY_MIN),
                                               {11'd0, days_in_month(year_q, month_d)}));
                        end
                        FLD_DAY: day_d = 11'(wrap_step({5'd0, day_q}, 16'(DAY_MIN),
                                                       {11'd0, days_in_month(year_q, month_q)},
                                                       step_up));
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end else if (sec_tick) begin
               if (tmo_q == TMO_LAST) state_d = ST_IDLE;
               else                   tmo_d   = tmo_q + TW'(1);
            end
         end

         ST_COMMIT: begin
            // Registered strobe: load rises one cycle after COMMIT is entered
            load_d  = en;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Blink phase: restarts visible on entry, free-runs only while editing
   always_comb begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
      if (state_d == ST_EDIT) begin
         if (state_q != ST_EDIT) begin
            blink_d = 1'b1;
         end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
         end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end
   end

   // State, shadow and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         field_q     <= FLD_HOUR;
         year_q      <= YR_LO;
         month_q     <= 6'd1;
         day_q       <= 11'd1;
         hour_q      <= '0;
         minute_q    <= '0;
         second_q    <= '0;
         tmo_q       <= '0;
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         field_q     <= field_d;
         year_q      <= year_d;
         month_q     <= month_d;
         day_q       <= day_d;
         hour_q      <= hour_d;
         minute_q    <= minute_d;
         second_q    <= second_d;
         tmo_q       <= tmo_d;
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
         load_q      <= load_d;
      end
   end

   assign set_year   = year_q;
   assign set_month  = month_q;
   assign set_day    = day_q;
   assign set_hour   = hour_q;
   assign set_minute = minute_q;
   assign set_second = second_q;
   assign load       = load_q;
   assign editing    = (state_q == ST_EDIT);
   assign field      = field_q;
   assign blink      = blink_q;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Sequencer for setting the running clock. It turns the debounced `up`/`down`/`left`/`right`/`middle` buttons into an edit session over a shadow copy of the time and date. When the user confirms, it issues a single-cycle load to `current_time`. It sits between `mode_selection` and `current_time`, and exports the selected field and a blink phase so `basic_clk`/`shower` can flash the digits being edited.

## Interface
Parameters:
- `YEAR_MIN`, 2000, lowest settable year
- `YEAR_MAX`, 2099, highest settable year (range keeps leap = year%4==0 exact)
- `TIMEOUT_S`, 30, number of `sec_tick` pulses without a button before the edit is abandoned
- `BLINK_DIV`, 50_000_000, `clk` cycles per `blink` toggle

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  high when the mode selector is in clock-set mode; a low level forces IDLE
- `sec_tick`  in  1  one-cycle pulse per second (from `divider`/`current_time` domain, already in `clk`)
- `up`, `down`, `left`, `right`, `middle`  in  1 each  debounced button levels
- `cur_year`  in  16  live time input, captured on entry
- `cur_month`  in  6  live time input, captured on entry
- `cur_day`, `cur_hour`, `cur_minute`, `cur_second`  in  11 each  live time inputs, captured on entry
- `set_year`  out  16  shadow value
- `set_month`  out  6  shadow value
- `set_day`, `set_hour`, `set_minute`, `set_second`  out  11 each  shadow values
- `load`  out  1  one-cycle commit strobe to `current_time`
- `editing`  out  1  high in EDIT
- `field`  out  3  selected field: 0 hour, 1 minute, 2 second, 3 year, 4 month, 5 day
- `blink`  out  1  blink phase; held 0 outside EDIT

## Operation
- Edge detection:
  - Each button has a registered previous value.
  - An event is `btn & ~btn_q`.
  - At most one event is acted on per cycle, with priority middle > right > left > up > down.
- FSM states: IDLE, EDIT, COMMIT.
- IDLE:
  - A middle event with `en`=1 captures all `cur_*` into the shadow, sets `field`=0, clears the timeout counter, and enters EDIT.
  - On capture, out-of-range values are clamped: year into [YEAR_MIN, YEAR_MAX], month into [1, 12], day into [1, dim], hour ≤ 23, minute/second ≤ 59.
- EDIT:
  - right: `field` +1, wrapping 5→0. left: `field` −1, wrapping 0→5.
  - up/down: increment/decrement the selected field with wrap:
    - hour 0..23
    - minute and second 0..59
    - month 1..12
    - year YEAR_MIN..YEAR_MAX
    - day 1..dim(year, month)
  - After any month or year change, day is clamped to the new dim (e.g. 31 Mar → Feb 2023 gives 28).
  - dim: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb gives 29 if year%4==0, else 28.
  - middle: go to COMMIT.
  - Timeout: the counter increments on `sec_tick` and clears on any accepted event. Reaching TIMEOUT_S returns to IDLE with no load.
  - `en` low: go to IDLE with no load.
- COMMIT: `load`=1 for exactly one cycle, then IDLE.
- `set_*` hold their last values in IDLE; `current_time` ignores them unless `load` is high.
- `week` is not edited; recomputing it is `current_time`'s job on load.

## Timing
- Reset values:
  - state IDLE
  - `set_year`=YEAR_MIN, `set_month`=1, `set_day`=1, `set_hour`/`set_minute`/`set_second`=0
  - `load`=0, `editing`=0, `field`=0, `blink`=0
  - edge registers 0, timeout and blink counters 0
- Latency:
  - A button rising at edge n (first sampled high with `btn_q`=0) updates the shadow/`field` at edge n, visible after it.
  - A middle event in EDIT at edge n gives `load` high in the cycle after edge n+1 (COMMIT), low again after edge n+2.
  - `set_*` are stable throughout the `load` cycle.
- Simultaneous events:
  - Event and timeout in the same cycle: the event wins and the counter clears.
  - `en` low and middle in the same cycle: `en` wins, no load.
- A held button produces one event only, with no auto-repeat.
- `rst` mid-EDIT or in COMMIT: IDLE next cycle, `load` never asserted, shadow reset.
- Blink: the counter runs only in EDIT and toggles `blink` every BLINK_DIV cycles. Entering EDIT restarts it with `blink`=1 (digits visible first).

## Structure
- `clock_pkg`: field index constants (FLD_HOUR..FLD_DAY), range limits, state encoding, and a `days_in_month(year, month)` function shared with `current_time`.
- Sub-module `btn_edge`: one instance holds the five previous-value registers and a priority-encoded event output.
- The rest is a single FSM plus arithmetic in `time_set_ctrl`.

## Test plan
1. Entry and hour wrap: cur=2024-05-10 23:59:58, `en`=1, middle, then up on hour → `editing`=1, `set_hour`=0, other fields unchanged.
2. Day clamp: edit to 2023-03-31, select month, down → month 2, day 28. Year 2024, Feb, day 31 attempt → 29. Day up from 29 in Feb 2024 → 1.
3. Commit: after edits, middle → exactly one `load` pulse 2 cycles later with set=2024-02-29 12:00:00; IDLE after.
4. Timeout with TIMEOUT_S=3: three `sec_tick` pulses, no buttons → IDLE, `load` never high. With an up event at the same edge as the 3rd tick → stays in EDIT.
5. Priority/hold: middle+up same cycle in EDIT → COMMIT, no increment. Up held 100 cycles → single increment.
6. Reset mid-edit: `rst` during EDIT → all outputs at reset values next cycle, no `load`. Year wrap: 2099 up → 2000.
